// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I-subset core: IDLE/FETCH/DECODE/EXECUTE/WRITEBACK over one datapath.
// Define MULTICYCLE_CPU_ILLEGAL_TRAP_EN to halt on illegal instructions (otherwise they retire as NOPs).
module multicycle_cpu #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  instret,
  output logic                  halted
);
  localparam int NREG = 2**ADDRESS_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_e;
  state_e state_q, state_d;

  logic [31:0]              ir_q;
  logic [PC_WIDTH-1:0]      pc_q;
  logic [DATA_WIDTH-1:0]    a_q, b_q, imm_q, alu_q, a0_q;
  logic [DATA_WIDTH-1:0]    rf_q [NREG];
  logic                     taken_q, req_q, req_d, instret_q, instret_d;
  logic                     ir_ld, ab_ld, alu_ld, wb_en;

  // Instruction field decode, straight off IR (stable from DECODE to WRITEBACK)
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [ADDRESS_WIDTH-1:0] rs1, rs2, rd;
  logic is_addi, is_r, is_br, legal, wr_rd;
  logic [DATA_WIDTH-1:0] imm_i, imm_b, alu_res;
  logic [PC_WIDTH-1:0]   imm_pc;

  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign f7  = ir_q[31:25];
  assign rs1 = ADDRESS_WIDTH'(ir_q[19:15]);
  assign rs2 = ADDRESS_WIDTH'(ir_q[24:20]);
  assign rd  = ADDRESS_WIDTH'(ir_q[11:7]);

  assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
  assign is_r    = (opc == 7'b0110011) &&
                   (((f3 == 3'b000) && ((f7 == 7'b0000000) || (f7 == 7'b0100000))) ||
                    (((f3 == 3'b110) || (f3 == 3'b111)) && (f7 == 7'b0000000)));
  assign is_br   = (opc == 7'b1100011) && (f3[2:1] == 2'b00);
  assign legal   = is_addi | is_r | is_br;
  assign wr_rd   = (is_addi | is_r) && (rd != '0);

  assign imm_i  = {{(DATA_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_b  = {{(DATA_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_pc = PC_WIDTH'($signed(imm_q));

  always_comb begin
    alu_res = a_q + imm_q;
    if (is_r) begin
      case (f3)
        3'b110:  alu_res = a_q | b_q;
        3'b111:  alu_res = a_q & b_q;
        default: alu_res = f7[5] ? (a_q - b_q) : (a_q + b_q);
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
`ifdef MULTICYCLE_CPU_ILLEGAL_TRAP_EN
      S_DECODE: state_d = legal ? S_EXEC : S_HALT;
`else
      S_DECODE: state_d = S_EXEC;
`endif
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs and datapath enables
  always_comb begin
    req_d     = (state_d == S_FETCH);
    instret_d = (state_q == S_WB);
    ir_ld     = (state_q == S_FETCH) && imem_ack;
    ab_ld     = (state_q == S_DECODE);
    alu_ld    = (state_q == S_EXEC) && legal && !is_br;
    wb_en     = (state_q == S_WB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q      <= '0;
      pc_q      <= RESET_PC;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      a0_q      <= '0;
      taken_q   <= 1'b0;
      req_q     <= 1'b0;
      instret_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      instret_q <= instret_d;
      if (ir_ld) ir_q <= imem_rdata;
      if (ab_ld) begin
        a_q   <= rf_q[rs1];
        b_q   <= rf_q[rs2];
        imm_q <= is_br ? imm_b : imm_i;
      end
      if (alu_ld) alu_q <= alu_res;
      if (state_q == S_EXEC) taken_q <= is_br && (f3[0] ? (a_q != b_q) : (a_q == b_q));
      if (wb_en) begin
        pc_q <= taken_q ? (pc_q + imm_pc) : (pc_q + PC_WIDTH'(4));
        if (wr_rd && (rd == ADDRESS_WIDTH'(10))) a0_q <= alu_q;
      end
    end
  end

  // x0 is never written, so it reads as zero without a read-side mux
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en && wr_rd) begin
      rf_q[rd] <= alu_q;
    end
  end

`ifdef MULTICYCLE_CPU_ILLEGAL_TRAP_EN
  logic halted_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= (state_d == S_HALT);
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign a0        = a0_q;
  assign ALUout    = alu_q;
  assign instret   = instret_q;
endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle RV32I-subset core: one shared datapath sequenced by a state machine (FETCH, DECODE, EXECUTE, WRITEBACK), so that instruction memory is external and may take any number of cycles to answer. It sits at the top of the CPU hierarchy in place of the single-cycle top. It keeps the `a0` and `ALUout` observation outputs and adds a fetch request/acknowledge handshake, a retire pulse and a halt indication.

## Interface
- `DATA_WIDTH`, 32: register, ALU and immediate width (≥ 32).
- `ADDRESS_WIDTH`, 5: register index width; register file holds 2**ADDRESS_WIDTH entries.
- `PC_WIDTH`, 32: program counter and `imem_addr` width.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request, registered.
- `imem_addr`  out  PC_WIDTH  fetch address (current PC).
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `a0`  out  DATA_WIDTH  registered mirror of register x10.
- `ALUout`  out  DATA_WIDTH  registered result of the last EXECUTE.
- `instret`  out  1  one-cycle pulse per retired instruction.
- `halted`  out  1  core stopped on an illegal instruction (see Configuration).

## Operation
- Supported instructions, all others illegal:
  - `ADDI` (opcode 0010011, funct3 000).
  - `ADD`/`SUB` (0110011, funct3 000, funct7 0000000/0100000).
  - `OR`/`AND` (0110011, funct3 110/111, funct7 0).
  - `BEQ`/`BNE` (1100011, funct3 000/001).
- Immediates are sign-extended to DATA_WIDTH.
- Arithmetic wraps modulo 2**DATA_WIDTH.
- Branch targets are PC+imm, truncated to PC_WIDTH.
- States:
  - IDLE: entered on reset; always moves to FETCH on the next edge.
  - FETCH: `imem_req`=1 and `imem_addr`=PC. On an edge with `imem_ack`=1, latch `imem_rdata` into IR and go to DECODE; otherwise stay in FETCH.
  - DECODE: read rs1/rs2 into A/B and form the immediate. An illegal IR goes to HALT or is treated as a NOP (see Configuration).
  - EXECUTE: compute the ALU result into `ALUout`; evaluate the branch condition (A==B for BEQ, A!=B for BNE).
  - WRITEBACK:
    - write rd if the instruction writes a register and rd≠0; x0 reads as 0 forever;
    - PC ← taken ? PC+imm : PC+4;
    - pulse `instret`;
    - go to FETCH.
  - HALT: terminal state; only `rst` leaves it.
- `a0` updates at the same edge as a write to x10.
- Branches do not modify `ALUout`; it keeps the prior value.

## Timing
- Reset values:
  - PC=RESET_PC;
  - all registers 0;
  - `a0`=0, `ALUout`=0;
  - `imem_req`=0, `instret`=0, `halted`=0;
  - state IDLE.
- `imem_req` rises on the first edge after `rst` deasserts.
- Minimum 4 cycles per instruction (ack in the first FETCH cycle).
- Each cycle of ack delay adds one cycle.
- `imem_addr` is stable while `imem_req`=1.
- `imem_ack` is ignored outside FETCH.
- `imem_req` drops on the edge that samples the ack.
- Reset asserted mid-instruction abandons it: no partial register or PC update, and all outputs return to reset values immediately.
- Write and read of the same register in consecutive instructions needs no forwarding; the write completes before the next DECODE.

## Configuration
- `MULTICYCLE_CPU_ILLEGAL_TRAP_EN` defined:
  - illegal IR in DECODE → HALT;
  - `halted`=1 from the next edge;
  - `imem_req`=0 and no further `instret`.
- Undefined:
  - illegal IR executes as a NOP: no register write, PC+4, `instret` pulses;
  - `halted` is tied 0.

## Test plan
- Reset then release, ack always 1 → one idle cycle, then `imem_req`=1 with `imem_addr`=0; `a0`=0, `ALUout`=0, `instret`=0.
- Fetch 0x00500513 (addi x10,x0,5) → `instret` 3 cycles after the ack edge; `a0`=5, `ALUout`=5, next `imem_addr`=4.
- Fetch in sequence:
  - addi x1,x0,7;
  - addi x2,x0,3;
  - sub x10,x1,x2;
  - addi x0,x0,9;
  - add x11,x0,x0.
  - Expected: `a0`=4, x0 stays 0, `ALUout`=0.
- Loop starting at PC 8 with x10=3: addi x10,x10,-1, then bne x10,x0,-4 → `a0` steps 2,1,0; the branch is taken twice, then falls through to `imem_addr`=16.
- `imem_ack` delayed 3 cycles per fetch → `imem_addr` held, no state advance, 7 cycles per instruction, results unchanged.
- Fetch 0xFFFFFFFF:
  - with the macro → `halted`=1, `imem_req` stays 0;
  - without → no state change except PC+4, `instret` pulses;
  - `rst` clears the halt in both builds.
